generic_pipe: RTL and testbench

- Parametrised elastic pipeline register: the successor to the single-stage enable flop.
- Carries a WIDTH-bit payload through DEPTH valid/ready stages with bubble collapsing, synchronous flush and occupancy reporting.
- Used wherever a timing cut is needed on a back-pressured data path (trace/debug funnels, packers, bus bridges).
- DEPTH=0 gives a pure combinational pass-through, so call sites can tune stage count without changing structure.

---
 rtl/generic_pipe.sv | 84 ++++++++
 tb/tb_generic_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_pipe.sv
// rtl/generic_pipe.sv - elastic valid/ready pipeline with bubble collapsing and flush
// Optional saturating stall counter when GENERIC_PIPE_STALL_CNT_EN is defined.
module generic_pipe #(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 16
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       flush,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [WIDTH-1:0]                           in_data,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [WIDTH-1:0]                           out_data,
`ifdef GENERIC_PIPE_STALL_CNT_EN
   output logic [((DEPTH == 0) ? 1 : $clog2(DEPTH + 1))-1:0] occupancy,
   output logic [CNT_W-1:0]                           stall_cnt
`else
   output logic [((DEPTH == 0) ? 1 : $clog2(DEPTH + 1))-1:0] occupancy
`endif
);

   localparam int OCC_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1);

   if (DEPTH == 0) begin : g_bypass
      assign in_ready  = out_ready && !flush;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign occupancy = '0;
   end else begin : g_pipe
      logic [DEPTH-1:0] v;
      logic [WIDTH-1:0] d [DEPTH];
      logic [DEPTH-1:0] rdy;

      // A stage can take new data when some stage at or beyond it has a hole,
      // or the consumer is draining; written flat to avoid a combinational chain.
      for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
         assign rdy[i] = out_ready || !(&v[DEPTH-1:i]);
      end

      always_ff @(posedge clk) begin
         if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               v[i] <= 1'b0;
               d[i] <= RESET_VALUE;
            end
         end else begin
            if (rdy[0]) begin
               v[0] <= in_valid;
               if (in_valid) d[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
               if (rdy[i]) begin
                  v[i] <= v[i-1];
                  if (v[i-1]) d[i] <= d[i-1];
               end
            end
         end
      end

      assign in_ready  = rdy[0] && !flush;
      assign out_valid = v[DEPTH-1];
      assign out_data  = d[DEPTH-1];

      always_comb begin
         occupancy = OCC_W'($countones(v));
      end
   end

`ifdef GENERIC_PIPE_STALL_CNT_EN
   // Survives flush so stall history is not lost when the pipe is cleared.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_generic_pipe.sv
// tb/tb_generic_pipe.sv - directed and random checks of generic_pipe against a slot-queue model
module tb_generic_pipe;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       ir3, ov3, ir2, ov2, ir0, ov0;
   logic [7:0] od3, od2, od0;
   logic [1:0] occ3, occ2;
   logic [0:0] occ0;
`ifdef GENERIC_PIPE_STALL_CNT_EN
   logic [1:0] stall3, stall2, stall0;
   int         mstall;
`endif

   int checks   = 0;
   int failures = 0;

   logic       mval [2][16];
   logic [7:0] mdat [2][16];
   int         mdep [2] = '{3, 2};
   logic [7:0] mrv  [2] = '{8'hA5, 8'h3C};

   generic_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5), .CNT_W(2)) u_d3 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
      .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
`ifdef GENERIC_PIPE_STALL_CNT_EN
      .occupancy(occ3), .stall_cnt(stall3)
`else
      .occupancy(occ3)
`endif
   );

   generic_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VALUE(8'h3C), .CNT_W(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
`ifdef GENERIC_PIPE_STALL_CNT_EN
      .occupancy(occ2), .stall_cnt(stall2)
`else
      .occupancy(occ2)
`endif
   );

   generic_pipe #(.WIDTH(8), .DEPTH(0), .RESET_VALUE(8'h00), .CNT_W(2)) u_d0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
`ifdef GENERIC_PIPE_STALL_CNT_EN
      .occupancy(occ0), .stall_cnt(stall0)
`else
      .occupancy(occ0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int m);
      for (int i = 0; i < 16; i++) begin
         mval[m][i] = 1'b0;
         mdat[m][i] = mrv[m];
      end
   endtask

   // Slots advance into holes from the output end backwards; input takes slot 0 if free.
   function automatic logic model_in_ready(input int m);
      logic vv [16];
      int   dep;
      dep = mdep[m];
      for (int i = 0; i < 16; i++) vv[i] = mval[m][i];
      if (vv[dep-1] && out_ready) vv[dep-1] = 1'b0;
      for (int i = dep - 2; i >= 0; i--) begin
         if (vv[i] && !vv[i+1]) begin
            vv[i+1] = 1'b1;
            vv[i]   = 1'b0;
         end
      end
      return !vv[0] && !flush;
   endfunction

   function automatic int model_occ(input int m);
      int n = 0;
      for (int i = 0; i < mdep[m]; i++) n += int'(mval[m][i]);
      return n;
   endfunction

   task automatic model_clock(input int m);
      int dep;
      dep = mdep[m];
      if (!rst_n || flush) begin
         model_reset(m);
      end else begin
         if (mval[m][dep-1] && out_ready) mval[m][dep-1] = 1'b0;
         for (int i = dep - 2; i >= 0; i--) begin
            if (mval[m][i] && !mval[m][i+1]) begin
               mval[m][i+1] = 1'b1;
               mdat[m][i+1] = mdat[m][i];
               mval[m][i]   = 1'b0;
            end
         end
         if (!mval[m][0] && in_valid) begin
            mval[m][0] = 1'b1;
            mdat[m][0] = in_data;
         end
      end
   endtask

   task automatic check_inst(input int m, input logic ir, input logic ov,
                             input logic [7:0] od, input logic [1:0] occ);
      int dep;
      dep = mdep[m];
      check($sformatf("d%0d_in_ready", dep),  32'(ir),  32'(model_in_ready(m)));
      check($sformatf("d%0d_out_valid", dep), 32'(ov),  32'(mval[m][dep-1]));
      check($sformatf("d%0d_out_data", dep),  32'(od),  32'(mdat[m][dep-1]));
      check($sformatf("d%0d_occupancy", dep), 32'(occ), 32'(model_occ(m)));
   endtask

   task automatic step();
      #2;
      check_inst(0, ir3, ov3, od3, occ3);
      check_inst(1, ir2, ov2, od2, occ2);
      check("d0_in_ready",  32'(ir0),  32'(out_ready && !flush));
      check("d0_out_valid", 32'(ov0),  32'(in_valid));
      check("d0_out_data",  32'(od0),  32'(in_data));
      check("d0_occupancy", 32'(occ0), 32'd0);
`ifdef GENERIC_PIPE_STALL_CNT_EN
      check("d3_stall_cnt", 32'(stall3), 32'(mstall));
`endif
      @(posedge clk);
`ifdef GENERIC_PIPE_STALL_CNT_EN
      if (!rst_n) mstall = 0;
      else if (mval[0][2] && !out_ready && mstall < 3) mstall++;
`endif
      model_clock(0);
      model_clock(1);
      #1;
   endtask

   task automatic push(input logic [7:0] data);
      in_valid = 1'b1;
      in_data  = data;
      step();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      model_reset(0);
      model_reset(1);
`ifdef GENERIC_PIPE_STALL_CNT_EN
      mstall = 0;
`endif
      step();
      #2;
      check("reset_out_data", 32'(od3), 32'h0000_00A5);
      check("reset_occupancy", 32'(occ3), 32'd0);
      rst_n = 1'b1;

      // back-to-back with free-running output
      push(8'h11); push(8'h22); push(8'h33);
      idle(5);

      // back-pressure: fourth beat refused until one pop
      out_ready = 1'b0;
      push(8'h44); push(8'h55); push(8'h66);
      in_valid = 1'b1;
      in_data  = 8'h77;
      #2;
      check("full_in_ready", 32'(ir3), 32'd0);
      check("full_out_data", 32'(od3), 32'h0000_0044);
      #1;
      step(); step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      idle(1);
      #2;
      check("swap_occupancy", 32'(occ3), 32'd3);
      #1;
      out_ready = 1'b1;
      idle(4);

      // bubble collapse
      out_ready = 1'b0;
      push(8'h0A);
      idle(2);
      push(8'h0B);
      idle(1);
      #2;
      check("bubble_occupancy", 32'(occ3), 32'd2);
      #1;
      out_ready = 1'b1;
      idle(3);

      // flush while full with an input beat offered
      out_ready = 1'b0;
      push(8'hC1); push(8'hC2); push(8'hC3);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      #2;
      check("flush_out_data", 32'(od3), 32'h0000_00A5);
      check("flush_out_valid", 32'(ov3), 32'd0);
      #1;
      idle(2);

      // reset mid-stream
      out_ready = 1'b1;
      push(8'hD1); push(8'hD2);
      rst_n = 1'b0;
      push(8'hD3);
      rst_n = 1'b1;
      idle(2);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst_n     = ($urandom_range(0, 63) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
